// File: rtl/generador_contadores_vga_pkg.sv
// Shared VGA timing constants and payload types for the counter stage and the sync generators.
package generador_contadores_vga_pkg;

    localparam int unsigned CNT_W   = 11;
    localparam int unsigned PRESC_W = 4;

    localparam int unsigned H_TOTAL  = 1600;
    localparam int unsigned V_TOTAL  = 521;
    localparam int unsigned H_ACTIVE = 1280;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned PIX_DIV  = 2;

    // HSync window bounds consumed downstream by the HSync generator.
    localparam int unsigned HSYNC_INI = 1;
    localparam int unsigned HSYNC_FIN = 1408;

    typedef struct packed {
        logic pixel_tick;
        logic fin_linea;
        logic fin_cuadro;
    } strobes_t;

endpackage

// File: rtl/generador_contadores_vga_divisor_pixel.sv
// Pixel-clock prescaler: one-clock tick every PIX_DIV enabled system clocks.
module generador_contadores_vga_divisor_pixel
    import generador_contadores_vga_pkg::*;
#(
    parameter int unsigned PIX_DIV = 2
) (
    input  logic clk,
    input  logic rstN,
    input  logic enable,
    output logic tick
);

    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PIX_DIV - 1);

    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_d;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // Holding enable low freezes the phase so resuming loses no tick.
    always_comb begin
        tick    = 1'b0;
        presc_d = presc_q;
        if (enable) begin
            if (presc_q == PRESC_MAX) begin
                tick    = 1'b1;
                presc_d = '0;
            end else begin
                presc_d = presc_q + PRESC_W'(1);
            end
        end
    end

endmodule

// File: rtl/generador_contadores_vga.sv
// VGA timing counters: horizontal/vertical position, line/frame strobes and active-video flag.
module generador_contadores_vga #(
    parameter int unsigned H_TOTAL  = generador_contadores_vga_pkg::H_TOTAL,
    parameter int unsigned V_TOTAL  = generador_contadores_vga_pkg::V_TOTAL,
    parameter int unsigned H_ACTIVE = generador_contadores_vga_pkg::H_ACTIVE,
    parameter int unsigned V_ACTIVE = generador_contadores_vga_pkg::V_ACTIVE,
    parameter int unsigned PIX_DIV  = generador_contadores_vga_pkg::PIX_DIV
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        enable,
    output logic        pixelTick,
    output logic [10:0] cntHorizontal,
    output logic [10:0] cntVertical,
    output logic        finLinea,
    output logic        finCuadro,
    output logic        videoActivo
);

    import generador_contadores_vga_pkg::*;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);

    logic             tick;
    logic [CNT_W-1:0] h_q;
    logic [CNT_W-1:0] h_d;
    logic [CNT_W-1:0] v_q;
    logic [CNT_W-1:0] v_d;
    strobes_t         strobes_q;
    strobes_t         strobes_d;

    generador_contadores_vga_divisor_pixel #(
        .PIX_DIV(PIX_DIV)
    ) u_divisor_pixel (
        .clk   (clk),
        .rstN  (rstN),
        .enable(enable),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            h_q       <= '0;
            v_q       <= '0;
            strobes_q <= '0;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            strobes_q <= strobes_d;
        end
    end

    // Strobes are registered alongside the counters so they line up with the new count.
    always_comb begin
        h_d                  = h_q;
        v_d                  = v_q;
        strobes_d            = '0;
        strobes_d.pixel_tick = tick;
        if (tick) begin
            if (h_q == H_LAST) begin
                h_d                 = '0;
                strobes_d.fin_linea = 1'b1;
                if (v_q == V_LAST) begin
                    v_d                  = '0;
                    strobes_d.fin_cuadro = 1'b1;
                end else begin
                    v_d = v_q + CNT_W'(1);
                end
            end else begin
                h_d = h_q + CNT_W'(1);
            end
        end
    end

    assign pixelTick     = strobes_q.pixel_tick;
    assign finLinea      = strobes_q.fin_linea;
    assign finCuadro     = strobes_q.fin_cuadro;
    assign cntHorizontal = h_q;
    assign cntVertical   = v_q;
    assign videoActivo   = (h_q < H_ACT) && (v_q < V_ACT);

endmodule
